// File: rtl/node_buffer_ctrl_param.sv
// Line buffer between the input interface and the bf16 multiply tree: fills wide lines into
// BRAM, replays them as narrow slices under backpressure, and tracks per-group max exponent.
module node_buffer_ctrl_param #(
    parameter int IN_WIDTH    = 256,
    parameter int SLICE_WIDTH = 128,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int LANES       = 4,
    parameter int GRP_W       = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      fill_len_minusone,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_vld,
    output logic                   in_ready,
    output logic [SLICE_WIDTH-1:0] mul_data,
    output logic                   mul_stb,
    input  logic                   mul_ready,
    input  logic [16*LANES-1:0]    res_data,
    input  logic                   res_vld,
    input  logic [GRP_W-1:0]       num_res_minusone,
    output logic [7:0]             max_exponent,
    output logic                   max_exponent_vld,
    output logic [1:0]             state
);

    localparam int RATIO = IN_WIDTH / SLICE_WIDTH;
    localparam int SL_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LO_N  = (LANES + 1) / 2;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1
    } state_t;

    state_t cur_st, nxt_st;

    function automatic logic [7:0] umax8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [IN_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]   waddr, fill_len, out_cnt;
    logic [ADDR_W:0]     rd_cnt;
    logic [IN_WIDTH-1:0] rdata, hold_line;
    logic                rvld_p1, hold_vld, cur_vld;
    logic [RATIO-1:0][SLICE_WIDTH-1:0] cur_line;
    logic [SL_W-1:0]     slice_idx;
    logic                wr_en, rd_en, xfer, line_done, drain_done, cur_free;
    logic [1:0]          occ;

    assign wr_en      = in_vld && in_ready;
    assign xfer       = cur_vld && mul_ready;
    assign line_done  = xfer && (slice_idx == SL_W'(RATIO - 1));
    assign drain_done = line_done && (out_cnt == fill_len);
    assign cur_free   = !cur_vld || line_done;
    // Lines owned by the drain side: output line, holding line, and a read in flight.
    assign occ        = 2'(cur_vld) + 2'(hold_vld) + 2'(rvld_p1);
    assign rd_en      = (cur_st == DRAIN) && (rd_cnt <= {1'b0, fill_len}) &&
                        ((occ - 2'(line_done)) < 2'd2);

    assign mul_stb  = cur_vld;
    assign mul_data = cur_vld ? cur_line[slice_idx] : '0;
    assign state    = cur_st;

    always_ff @(posedge clk) begin
        if (rst) cur_st <= FILL;
        else     cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st   = cur_st;
        in_ready = 1'b0;
        case (cur_st)
            FILL: begin
                in_ready = 1'b1;
                if (in_vld && (waddr == fill_len)) nxt_st = DRAIN;
            end
            DRAIN:   if (drain_done) nxt_st = FILL;
            default: nxt_st = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr     <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            fill_len  <= fill_len_minusone;
            rvld_p1   <= 1'b0;
            hold_vld  <= 1'b0;
            cur_vld   <= 1'b0;
            slice_idx <= '0;
        end else begin
            rvld_p1 <= rd_en;
            if (wr_en)     waddr     <= (waddr == fill_len) ? '0 : waddr + 1'b1;
            if (rd_en)     rd_cnt    <= rd_cnt + 1'b1;
            if (xfer)      slice_idx <= line_done ? '0 : slice_idx + 1'b1;
            if (line_done) out_cnt   <= out_cnt + 1'b1;
            if (drain_done) begin
                rd_cnt   <= '0;
                out_cnt  <= '0;
                fill_len <= fill_len_minusone;
            end
            if (cur_free) begin
                cur_vld  <= hold_vld || rvld_p1;
                hold_vld <= hold_vld && rvld_p1;
            end else if (rvld_p1) begin
                hold_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[waddr] <= in_data;
        if (rd_en) rdata <= mem[rd_cnt[ADDR_W-1:0]];
    end

    // rdata (p1) feeds the output line directly or parks in the holding line
    always_ff @(posedge clk) begin
        if (cur_free) begin
            if (hold_vld) begin
                cur_line <= hold_line;
                if (rvld_p1) hold_line <= rdata;
            end else if (rvld_p1) begin
                cur_line <= rdata;
            end
        end else if (rvld_p1) begin
            hold_line <= rdata;
        end
    end

    logic [7:0]       lo_max, hi_max;
    logic [GRP_W-1:0] grp_cnt, grp_len, grp_lim;
    logic             grp_last;

    always_comb begin
        lo_max = '0;
        hi_max = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < LO_N) lo_max = umax8(lo_max, res_data[16*k+7 +: 8]);
            else          hi_max = umax8(hi_max, res_data[16*k+7 +: 8]);
        end
    end

    assign grp_lim  = (grp_cnt == '0) ? num_res_minusone : grp_len;
    assign grp_last = res_vld && (grp_cnt == grp_lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_cnt <= '0;
            grp_len <= '0;
        end else if (res_vld) begin
            if (grp_cnt == '0) grp_len <= num_res_minusone;
            grp_cnt <= grp_last ? '0 : grp_cnt + 1'b1;
        end
    end

    logic [7:0] lo_p0, hi_p0, bmax_p1, acc_p2, grp_max;
    logic       vld_p0, last_p0, vld_p1, last_p1;

    assign grp_max = umax8(acc_p2, bmax_p1);

    // p0: half-lane maxima; p1: beat maximum; p2: group accumulator and pulse
    always_ff @(posedge clk) begin
        lo_p0   <= lo_max;
        hi_p0   <= hi_max;
        bmax_p1 <= umax8(lo_p0, hi_p0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0           <= 1'b0;
            last_p0          <= 1'b0;
            vld_p1           <= 1'b0;
            last_p1          <= 1'b0;
            acc_p2           <= '0;
            max_exponent     <= '0;
            max_exponent_vld <= 1'b0;
        end else begin
            vld_p0           <= res_vld;
            last_p0          <= grp_last;
            vld_p1           <= vld_p0;
            last_p1          <= last_p0;
            max_exponent_vld <= vld_p1 && last_p1;
            max_exponent     <= (vld_p1 && last_p1) ? grp_max : '0;
            if (vld_p1) acc_p2 <= last_p1 ? '0 : grp_max;
        end
    end

endmodule
